// File: rtl/pix_xfer_sched_pkg.sv
// Shared types for the pixel transfer scheduler: frame sequencer states and
// the frame length/counter width.
package pix_pkg;
  localparam int LEN_W = 32;

  typedef enum logic [2:0] {
    CLEAR,
    LOAD,
    PROC,
    DUMP_RD,
    DUMP_TX,
    DUMP_GAP
  } state_t;
endpackage

// File: rtl/pix_xfer_sched_if.sv
// Byte-path bundle between the scheduler and its UART/FIFO/processing
// neighbours; master is the scheduler side, slave is the environment side.
interface pix_xfer_sched_if
  import pix_pkg::*;
#(
  parameter int D_BITS = 8
);
  logic [LEN_W-1:0]  i_frame_len;
  logic              i_rx_valid;
  logic [D_BITS-1:0] i_rx_data;
  logic              o_buf_srst;
  logic              o_buf_wr_en;
  logic [D_BITS-1:0] o_buf_wr_data;
  logic              i_buf_full;
  logic              i_buf_empty;
  logic              o_buf_rd_en;
  logic [D_BITS-1:0] i_buf_rd_data;
  logic              o_proc_start;
  logic              i_proc_done;
  logic              i_tx_rdy;
  logic              o_tx_valid;
  logic [D_BITS-1:0] o_tx_data;
  logic              o_busy;
  logic              o_overflow;
  logic              o_proc_timeout;

  modport master (
    input  i_frame_len, i_rx_valid, i_rx_data, i_buf_full, i_buf_empty,
           i_buf_rd_data, i_proc_done, i_tx_rdy,
    output o_buf_srst, o_buf_wr_en, o_buf_wr_data, o_buf_rd_en, o_proc_start,
           o_tx_valid, o_tx_data, o_busy, o_overflow, o_proc_timeout
  );

  modport slave (
    output i_frame_len, i_rx_valid, i_rx_data, i_buf_full, i_buf_empty,
           i_buf_rd_data, i_proc_done, i_tx_rdy,
    input  o_buf_srst, o_buf_wr_en, o_buf_wr_data, o_buf_rd_en, o_proc_start,
           o_tx_valid, o_tx_data, o_busy, o_overflow, o_proc_timeout
  );
endinterface

// File: rtl/pix_xfer_sched_watchdog.sv
// Cycle timer for the PROC phase: counts while armed, clears when disarmed,
// and flags expiry on the last allowed cycle unless done arrives with it.
module pix_proc_watchdog #(
  parameter int unsigned TIMEOUT = 1048576
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic arm,
  input  logic done,
  output logic expired
);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] tmr_q, tmr_d;

  always_comb begin
    tmr_d = tmr_q;
    if (!arm) begin
      tmr_d = '0;
    end else if (tmr_q != '1) begin
      tmr_d = tmr_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tmr_q <= '0;
    end else begin
      tmr_q <= tmr_d;
    end
  end

  assign expired = arm && !done && (tmr_q == TW'(TIMEOUT - 1));
endmodule

// File: rtl/pix_xfer_sched.sv
// Frame sequencer for the pixel byte path: clear buffer, load one frame from
// RX, optionally run the processing core, then drain the frame to TX.
module pix_xfer_sched
  import pix_pkg::*;
#(
  parameter int          D_BITS       = 8,
  parameter int          PROC_EN      = 1,
  parameter int unsigned PROC_TIMEOUT = 1048576
) (
  input logic              i_clk,
  input logic              i_rst_n,
  pix_xfer_sched_if.master bus
);
  state_t            state_q, state_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              srst_q, srst_d;
  logic              start_q, start_d;
  logic              tx_valid_q, tx_valid_d;
  logic [D_BITS-1:0] tx_data_q, tx_data_d;
  logic              ovf_q, ovf_d;
  logic              pto_q, pto_d;
  logic              wr_en;
  logic              rd_en;
  logic              wd_expired;

  pix_proc_watchdog #(
    .TIMEOUT (PROC_TIMEOUT)
  ) u_wd (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .arm     (state_q == PROC),
    .done    (bus.i_proc_done),
    .expired (wd_expired)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    srst_d     = 1'b0;
    start_d    = 1'b0;
    tx_valid_d = 1'b0;
    tx_data_d  = tx_data_q;
    ovf_d      = ovf_q;
    pto_d      = pto_q;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    unique case (state_q)
      CLEAR: begin
        len_d = bus.i_frame_len;
        cnt_d = '0;
        if (bus.i_frame_len != '0) state_d = LOAD;
      end
      LOAD: begin
        if (bus.i_rx_valid) begin
          if (bus.i_buf_full) begin
            ovf_d = 1'b1;
          end else begin
            wr_en = 1'b1;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q + 1'b1 == len_q) begin
              cnt_d = '0;
              if (PROC_EN != 0) begin
                state_d = PROC;
                start_d = 1'b1;
              end else begin
                state_d = DUMP_RD;
              end
            end
          end
        end
      end
      PROC: begin
        // done has priority: the watchdog masks expiry in the done cycle
        if (bus.i_proc_done) begin
          state_d = DUMP_RD;
        end else if (wd_expired) begin
          pto_d   = 1'b1;
          state_d = DUMP_RD;
        end
      end
      DUMP_RD: begin
        if (bus.i_tx_rdy && !bus.i_buf_empty) begin
          rd_en   = 1'b1;
          state_d = DUMP_TX;
        end
      end
      DUMP_TX: begin
        tx_data_d  = bus.i_buf_rd_data;
        tx_valid_d = 1'b1;
        cnt_d      = cnt_q + 1'b1;
        state_d    = DUMP_GAP;
      end
      DUMP_GAP: begin
        if (cnt_q == len_q) begin
          state_d = CLEAR;
          srst_d  = 1'b1;
        end else begin
          state_d = DUMP_RD;
        end
      end
      default: begin
        state_d = CLEAR;
        srst_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= CLEAR;
      cnt_q      <= '0;
      len_q      <= '0;
      srst_q     <= 1'b1;
      start_q    <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      ovf_q      <= 1'b0;
      pto_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      srst_q     <= srst_d;
      start_q    <= start_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      ovf_q      <= ovf_d;
      pto_q      <= pto_d;
    end
  end

  assign bus.o_buf_srst     = srst_q;
  assign bus.o_buf_wr_en    = wr_en;
  assign bus.o_buf_wr_data  = wr_en ? bus.i_rx_data : '0;
  assign bus.o_buf_rd_en    = rd_en;
  assign bus.o_proc_start   = start_q;
  assign bus.o_tx_valid     = tx_valid_q;
  assign bus.o_tx_data      = tx_data_q;
  assign bus.o_busy         = (state_q != CLEAR);
  assign bus.o_overflow     = ovf_q;
  assign bus.o_proc_timeout = pto_q;
endmodule

// File: tb/tb_pix_xfer_sched.sv
// Directed bench: two schedulers (PROC disabled / PROC with a 16-cycle
// timeout), each backed by a small FIFO model, checked against hand values.
module tb_pix_xfer_sched;
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pix_xfer_sched_if #(.D_BITS(8)) if0 ();
  pix_xfer_sched_if #(.D_BITS(8)) if1 ();

  pix_xfer_sched #(.D_BITS(8), .PROC_EN(0), .PROC_TIMEOUT(16)) u_dut0 (
    .i_clk (clk), .i_rst_n (rst_n), .bus (if0)
  );
  pix_xfer_sched #(.D_BITS(8), .PROC_EN(1), .PROC_TIMEOUT(16)) u_dut1 (
    .i_clk (clk), .i_rst_n (rst_n), .bus (if1)
  );

  // FIFO models (depth 16, 1-cycle read latency)
  logic [7:0] q0[$], q1[$];
  logic [7:0] rd0 = '0, rd1 = '0;
  int         n0 = 0, n1 = 0;
  logic       force_full0 = 1'b0;

  always @(posedge clk) begin
    if (if0.o_buf_srst) q0.delete();
    else begin
      if (if0.o_buf_rd_en && q0.size() > 0) rd0 <= q0.pop_front();
      if (if0.o_buf_wr_en) q0.push_back(if0.o_buf_wr_data);
    end
    n0 <= q0.size();
  end
  always @(posedge clk) begin
    if (if1.o_buf_srst) q1.delete();
    else begin
      if (if1.o_buf_rd_en && q1.size() > 0) rd1 <= q1.pop_front();
      if (if1.o_buf_wr_en) q1.push_back(if1.o_buf_wr_data);
    end
    n1 <= q1.size();
  end
  assign if0.i_buf_empty   = (n0 == 0);
  assign if0.i_buf_full    = force_full0 || (n0 >= 16);
  assign if0.i_buf_rd_data = rd0;
  assign if1.i_buf_empty   = (n1 == 0);
  assign if1.i_buf_full    = (n1 >= 16);
  assign if1.i_buf_rd_data = rd1;

  // Output monitors, sampled on the falling edge
  int wr_n0 = 0, srst_n0 = 0, rd_n0 = 0, busy_n0 = 0, start_n0 = 0;
  int start_n1 = 0, start_cyc1 = 0, pto_cyc1 = 0;
  logic pto_prev1 = 1'b0;
  logic [7:0] txd0[$], txd1[$];
  int txc0[$], rdc1[$];

  always @(negedge clk) begin
    if (if0.o_buf_wr_en)  wr_n0    <= wr_n0 + 1;
    if (if0.o_buf_srst)   srst_n0  <= srst_n0 + 1;
    if (if0.o_buf_rd_en)  rd_n0    <= rd_n0 + 1;
    if (if0.o_busy)       busy_n0  <= busy_n0 + 1;
    if (if0.o_proc_start) start_n0 <= start_n0 + 1;
    if (if0.o_tx_valid) begin
      txd0.push_back(if0.o_tx_data);
      txc0.push_back(cyc);
    end
  end
  always @(negedge clk) begin
    if (if1.o_proc_start) begin
      start_n1   <= start_n1 + 1;
      start_cyc1 <= cyc;
    end
    if (if1.o_proc_timeout && !pto_prev1) pto_cyc1 <= cyc;
    pto_prev1 <= if1.o_proc_timeout;
    if (if1.o_buf_rd_en) rdc1.push_back(cyc);
    if (if1.o_tx_valid) txd1.push_back(if1.o_tx_data);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rx0(input logic [7:0] d);
    if0.i_rx_valid = 1'b1; if0.i_rx_data = d; tick(1);
    if0.i_rx_valid = 1'b0; if0.i_rx_data = '0; tick(1);
  endtask

  task automatic rx1(input logic [7:0] d);
    if1.i_rx_valid = 1'b1; if1.i_rx_data = d; tick(1);
    if1.i_rx_valid = 1'b0; if1.i_rx_data = '0; tick(1);
  endtask

  task automatic wait_tx(input int which, input int n, input int budget, input string tag);
    int k = 0;
    while (((which == 0) ? txd0.size() : txd1.size()) < n && k < budget) begin
      tick(1);
      k++;
    end
    if (k >= budget) check_eq(tag, (which == 0) ? txd0.size() : txd1.size(), n);
  endtask

  initial begin
    int b_tx, b_wr, b_srst, b_rd, b_busy, b_st, r_cyc, k;
    logic [7:0] exp4[4];
    logic [7:0] exp3[3];
    exp4 = '{8'h11, 8'h22, 8'h33, 8'h44};
    exp3 = '{8'hA1, 8'hA3, 8'hA4};

    rst_n = 1'b0;
    if0.i_frame_len = '0; if0.i_rx_valid = 1'b0; if0.i_rx_data = '0;
    if0.i_proc_done = 1'b0; if0.i_tx_rdy = 1'b0;
    if1.i_frame_len = '0; if1.i_rx_valid = 1'b0; if1.i_rx_data = '0;
    if1.i_proc_done = 1'b0; if1.i_tx_rdy = 1'b0;
    tick(3);

    // Reset state
    check_eq("rst_busy", if0.o_busy, 0);
    check_eq("rst_srst", if0.o_buf_srst, 1);
    check_eq("rst_txv", if0.o_tx_valid, 0);
    check_eq("rst_start", if1.o_proc_start, 0);

    // len=4, no PROC, rdy held high
    if0.i_frame_len = 32'd4; if0.i_tx_rdy = 1'b1;
    b_tx = txd0.size(); b_wr = wr_n0; b_srst = srst_n0;
    rst_n = 1'b1;
    tick(1);
    if0.i_rx_valid = 1'b1; if0.i_rx_data = 8'h11; #1;
    check_eq("wr_en_same_cycle", if0.o_buf_wr_en, 1);
    check_eq("wr_data_pass", if0.o_buf_wr_data, 32'h11);
    tick(1);
    if0.i_rx_valid = 1'b0; tick(1);
    rx0(8'h22); rx0(8'h33); rx0(8'h44);
    if0.i_frame_len = 32'd3;
    wait_tx(0, b_tx + 4, 100, "t1_tx_timeout");
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("t1_tx%0d", i), txd0[b_tx + i], exp4[i]);
      if (i > 0) check_eq($sformatf("t1_gap%0d", i), txc0[b_tx + i] - txc0[b_tx + i - 1], 3);
    end
    check_eq("t1_wr_cnt", wr_n0 - b_wr, 4);
    tick(2);
    check_eq("t1_srst_cnt", srst_n0 - b_srst, 2);
    check_eq("t1_ovf", if0.o_overflow, 0);
    check_eq("t1_no_start", start_n0, 0);

    // len=3 with buffer full during 2nd byte
    b_tx = txd0.size(); b_wr = wr_n0;
    rx0(8'hA1);
    force_full0 = 1'b1; rx0(8'hA2); force_full0 = 1'b0;
    check_eq("t2_ovf", if0.o_overflow, 1);
    rx0(8'hA3);
    tick(10);
    check_eq("t2_wr_before_4th", wr_n0 - b_wr, 2);
    check_eq("t2_no_tx_yet", txd0.size() - b_tx, 0);
    rx0(8'hA4);
    if0.i_frame_len = 32'd2;
    wait_tx(0, b_tx + 3, 100, "t2_tx_timeout");
    for (int i = 0; i < 3; i++) check_eq($sformatf("t2_tx%0d", i), txd0[b_tx + i], exp3[i]);
    check_eq("t2_wr_cnt", wr_n0 - b_wr, 3);
    if0.i_tx_rdy = 1'b0;

    // rdy low for 50 cycles during DUMP; RX outside LOAD ignored
    tick(1);
    b_tx = txd0.size(); b_wr = wr_n0; b_rd = rd_n0;
    rx0(8'h5A); rx0(8'hC3);
    tick(20); rx0(8'hEE); tick(28);
    check_eq("t5_no_rd", rd_n0 - b_rd, 0);
    check_eq("t5_no_tx", txd0.size() - b_tx, 0);
    check_eq("t5_rx_ignored", wr_n0 - b_wr, 2);
    if0.i_frame_len = '0;
    if0.i_tx_rdy = 1'b1; r_cyc = cyc;
    wait_tx(0, b_tx + 2, 100, "t5_tx_timeout");
    check_eq("t5_tx0", txd0[b_tx], 32'h5A);
    check_eq("t5_tx1", txd0[b_tx + 1], 32'hC3);
    check_eq("t5_rdy_latency", txc0[b_tx] - r_cyc, 2);
    tick(2);
    b_busy = busy_n0; b_srst = srst_n0;
    tick(20);
    check_eq("t5_idle_busy", busy_n0 - b_busy, 0);
    check_eq("t5_idle_srst", srst_n0 - b_srst, 0);

    // reset after 2 of 5 bytes transmitted
    if0.i_frame_len = 32'd5;
    tick(1);
    b_tx = txd0.size();
    rx0(8'h61); rx0(8'h62); rx0(8'h63); rx0(8'h64); rx0(8'h65);
    wait_tx(0, b_tx + 2, 100, "t6_tx_timeout");
    rst_n = 1'b0; #1;
    check_eq("t6_busy", if0.o_busy, 0);
    check_eq("t6_rd_en", if0.o_buf_rd_en, 0);
    check_eq("t6_txv", if0.o_tx_valid, 0);
    check_eq("t6_tx_data", if0.o_tx_data, 0);
    check_eq("t6_ovf_clr", if0.o_overflow, 0);
    check_eq("t6_srst", if0.o_buf_srst, 1);
    b_tx = txd0.size();
    tick(2);
    if0.i_frame_len = 32'd2;
    check_eq("t6_no_partial_tx", txd0.size() - b_tx, 0);
    b_srst = srst_n0;
    rst_n = 1'b1;
    tick(1);
    rx0(8'h01); rx0(8'h02);
    if0.i_frame_len = '0;
    wait_tx(0, b_tx + 2, 100, "t6b_tx_timeout");
    check_eq("t6b_tx0", txd0[b_tx], 32'h01);
    check_eq("t6b_tx1", txd0[b_tx + 1], 32'h02);
    check_eq("t6b_srst_once", srst_n0 - b_srst, 1);

    // PROC with no done: timeout after 16 cycles
    if1.i_frame_len = 32'd2; if1.i_tx_rdy = 1'b1;
    tick(1);
    b_tx = txd1.size(); b_st = start_n1;
    rx1(8'h7E); rx1(8'h81);
    if1.i_frame_len = '0;
    wait_tx(1, b_tx + 2, 100, "t3_tx_timeout");
    check_eq("t3_start_once", start_n1 - b_st, 1);
    check_eq("t3_pto", if1.o_proc_timeout, 1);
    check_eq("t3_pto_cycle", pto_cyc1 - start_cyc1, 16);
    check_eq("t3_rd_cycle", rdc1[rdc1.size() - 2] - start_cyc1, 16);
    check_eq("t3_tx0", txd1[b_tx], 32'h7E);
    check_eq("t3_tx1", txd1[b_tx + 1], 32'h81);

    // done coincident with the timeout cycle
    rst_n = 1'b0; tick(2);
    check_eq("t4_pto_rst", if1.o_proc_timeout, 0);
    if1.i_frame_len = 32'd2;
    rst_n = 1'b1;
    tick(1);
    b_tx = txd1.size(); b_st = start_n1;
    rx1(8'h99); rx1(8'h3C);
    if1.i_frame_len = '0;
    k = 0;
    while (start_n1 == b_st && k < 50) begin tick(1); k++; end
    check_eq("t4_start_seen", start_n1 - b_st, 1);
    k = 0;
    while (cyc < start_cyc1 + 15 && k < 50) begin tick(1); k++; end
    if1.i_proc_done = 1'b1; tick(1); if1.i_proc_done = 1'b0;
    wait_tx(1, b_tx + 2, 100, "t4_tx_timeout");
    check_eq("t4_pto", if1.o_proc_timeout, 0);
    check_eq("t4_rd_cycle", rdc1[rdc1.size() - 2] - start_cyc1, 16);
    check_eq("t4_tx0", txd1[b_tx], 32'h99);
    check_eq("t4_tx1", txd1[b_tx + 1], 32'h3C);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/pix_xfer_sched.md
Name: pix_xfer_sched

Overview:
- Frame-level sequencer for the pixel byte path: UART RX → pixel buffer FIFO → optional processing core → UART TX.
- Runs a repeating cycle:
  - clear the buffer;
  - load exactly one frame of bytes;
  - hand the frame to the processing core and wait for done, bounded by a timeout;
  - drain the frame to the transmitter under its ready handshake.
- Sits between the UART wrappers and the FIFO pair. Owns the FIFO reset, write enable and read enable.

Parameters:
- D_BITS, 8, pixel byte width.
- PROC_EN, 1, 1 = run the PROC phase; 0 = go LOAD→DUMP directly.
- PROC_TIMEOUT, 1048576, maximum cycles spent in PROC before forced exit; must be ≥1.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_frame_len  in  32  frame length in bytes; sampled only in CLEAR.
- i_rx_valid  in  1  one-cycle strobe: RX byte available.
- i_rx_data  in  D_BITS  RX byte.
- o_buf_srst  out  1  synchronous reset pulse to the buffer FIFOs.
- o_buf_wr_en  out  1  buffer write enable.
- o_buf_wr_data  out  D_BITS  buffer write data.
- i_buf_full  in  1  buffer full.
- i_buf_empty  in  1  buffer empty.
- o_buf_rd_en  out  1  buffer read enable; data valid 1 cycle later.
- i_buf_rd_data  in  D_BITS  buffer read data.
- o_proc_start  out  1  one-cycle start pulse to the processing core.
- i_proc_done  in  1  one-cycle done pulse from the processing core.
- i_tx_rdy  in  1  transmitter idle.
- o_tx_valid  out  1  one-cycle strobe: send o_tx_data.
- o_tx_data  out  D_BITS  registered TX byte.
- o_busy  out  1  high in every state except CLEAR.
- o_overflow  out  1  sticky: an RX byte was dropped because the buffer was full.
- o_proc_timeout  out  1  sticky: PROC exited on timeout.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - state = CLEAR, counters = 0.
  - All outputs 0, except o_buf_srst = 1 during reset and for the first CLEAR cycle.
  - Sticky flags clear only on reset.
- States (enum in package): CLEAR, LOAD, PROC, DUMP_RD, DUMP_TX, DUMP_GAP.
- CLEAR:
  - o_buf_srst = 1 for one cycle.
  - Latch len = i_frame_len; cnt = 0.
  - If len == 0, stay in CLEAR and resample every cycle. Otherwise go to LOAD next cycle.
- LOAD:
  - On i_rx_valid && !i_buf_full: o_buf_wr_en = 1, o_buf_wr_data = i_rx_data (combinational pass-through, same cycle), cnt++.
  - On i_rx_valid && i_buf_full: byte dropped, not counted, o_overflow set.
  - When the accepted byte makes cnt == len: go to PROC if PROC_EN, else DUMP_RD; cnt = 0.
  - Exactly len bytes are written; no off-by-one.
- PROC:
  - o_proc_start pulses on the first cycle in PROC only.
  - Timer counts cycles in PROC.
  - i_proc_done → DUMP_RD.
  - If timer reaches PROC_TIMEOUT-1 without done: set o_proc_timeout, go to DUMP_RD.
  - A done pulse in the same cycle as the timeout counts as done; the flag is not set.
- RX outside LOAD: i_rx_valid ignored in every state except LOAD. No write, no flag.
- DUMP_RD:
  - If i_tx_rdy && !i_buf_empty: o_buf_rd_en = 1 for one cycle, go to DUMP_TX.
  - Otherwise wait, with no timeout.
- DUMP_TX:
  - o_tx_data <= i_buf_rd_data; o_tx_valid = 1 (registered, one cycle); cnt++.
  - Go to DUMP_GAP.
- DUMP_GAP:
  - One idle cycle so the transmitter can drop i_tx_rdy; i_tx_rdy is not sampled.
  - If cnt == len, go to CLEAR; else go to DUMP_RD.
- Latency:
  - RX strobe → buffer write: 0 cycles.
  - i_tx_rdy high with data present → o_tx_valid: 2 cycles.
  - Minimum byte spacing on TX: 3 cycles.
- Frame completion: CLEAR is entered only after exactly len TX strobes.
- i_frame_len changes outside CLEAR have no effect.
- Width rules:
  - cnt and len are 32-bit unsigned.
  - The timer is $clog2(PROC_TIMEOUT+1) bits wide and saturates.
- Reset mid-frame: immediate return to CLEAR. Buffer contents are discarded via o_buf_srst, and no partial TX strobe is emitted.

Decomposition:
- Package pix_pkg:
  - state_t enum;
  - localparam LEN_W = 32.
- Sub-module pix_proc_watchdog: start/done/timeout counter (inputs arm, done; outputs expired). All other logic lives in the top.

Test Plan:
- len=4, PROC_EN=0, RX bytes 0x11,0x22,0x33,0x44, i_tx_rdy held 1 → exactly 4 o_buf_wr_en pulses; TX strobes 0x11..0x44 spaced 3 cycles apart; then CLEAR with one o_buf_srst pulse.
- len=3, i_buf_full forced high during the 2nd RX byte → that byte is not written; o_overflow=1; LOAD waits for a 4th RX byte before exiting.
- PROC_EN=1, len=2, PROC_TIMEOUT=16, no done → o_proc_start pulses once; after 16 cycles in PROC, o_proc_timeout=1; DUMP still sends 2 bytes.
- PROC_EN=1, done and timeout asserted in the same cycle → DUMP entered; o_proc_timeout stays 0.
- i_tx_rdy low for 50 cycles during DUMP → no o_buf_rd_en and no o_tx_valid until rdy rises; byte order preserved; i_frame_len=0 in CLEAR → o_busy stays 0 indefinitely.
- Assert i_rst_n=0 after 2 of 5 bytes have been transmitted → all outputs 0 immediately; after release: CLEAR, o_buf_srst pulse, and the next frame starts clean.
